fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit.sv | 143 ++++++++++++++
 tb/tb_fetch_unit.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch stage with one-bubble redirect and halt
//
// Ports:
//   clk          in   sole clock, rising edge
//   reset        in   asynchronous active-high reset
//   start        in   pulse: begin fetching at address 0 (IDLE or HALT only)
//   stall        in   downstream hold; freezes address, pc, valid and state
//   br_taken     in   redirect request for the presented instruction
//   br_imm[3:0]  in   jump immediate from decode
//   imem_addr    out  registered ROM address (PC_W bits)
//   imem_data    in   ROM data, one cycle after imem_addr
//   instr        out  imem_data passed through to the decoder
//   instr_valid  out  instr is a live instruction
//   pc_out       out  address of the presented instruction (PC_W bits)
//   done         out  high while halted
//   lut_we, lut_idx, lut_data  in  jump table write port (FETCH_BRANCH_LUT_EN only)
//
// FETCH_BRANCH_LUT_EN: when defined the jump target is lut[br_imm] from a
// 16-entry writable table; otherwise it is pc_out + sign-extended br_imm.

module fetch_unit #(
  parameter int         PC_W    = 10,
  parameter logic [8:0] HALT_OP = 9'h1FF
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            stall,
  input  logic            br_taken,
  input  logic [3:0]      br_imm,
  output logic [PC_W-1:0] imem_addr,
  input  logic [8:0]      imem_data,
  output logic [8:0]      instr,
  output logic            instr_valid,
  output logic [PC_W-1:0] pc_out,
  output logic            done
`ifdef FETCH_BRANCH_LUT_EN
  ,
  input  logic            lut_we,
  input  logic [3:0]      lut_idx,
  input  logic [PC_W-1:0] lut_data
`endif
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_PRIME = 2'd1;
  localparam logic [1:0] S_RUN   = 2'd2;
  localparam logic [1:0] S_HALT  = 2'd3;

  logic [1:0]      state_q, state_d;
  logic [PC_W-1:0] addr_q, addr_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic            valid_q, valid_d;
  logic [PC_W-1:0] target;
  logic            accept_halt;
  logic            accept_br;

  assign imem_addr   = addr_q;
  assign instr       = imem_data;
  assign instr_valid = valid_q;
  assign pc_out      = pc_q;
  assign done        = (state_q == S_HALT);

  // Halt outranks a redirect on the same presented instruction.
  assign accept_halt = (state_q == S_RUN) && valid_q && !stall && (imem_data == HALT_OP);
  assign accept_br   = (state_q == S_RUN) && valid_q && !stall && br_taken && !accept_halt;

`ifdef FETCH_BRANCH_LUT_EN
  logic [PC_W-1:0] lut_q [16];

  // Read is combinational from the registered table, so a write landing on
  // the same edge as a redirect is only seen by later redirects.
  assign target = lut_q[br_imm];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 16; i++) lut_q[i] <= '0;
    end else if (lut_we) begin
      lut_q[lut_idx] <= lut_data;
    end
  end
`else
  logic [PC_W-1:0] imm_ext;

  assign imm_ext = PC_W'($signed(br_imm));
  assign target  = pc_q + imm_ext;
`endif

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    pc_d    = pc_q;
    valid_d = valid_q;
    case (state_q)
      S_IDLE, S_HALT: begin
        if (start) begin
          state_d = S_PRIME;
          addr_d  = '0;
          valid_d = 1'b0;
        end
      end
      S_PRIME: begin
        // Address 0 is now in flight; its data arrives with the first RUN cycle.
        state_d = S_RUN;
        pc_d    = addr_q;
        addr_d  = addr_q + PC_W'(1);
        valid_d = 1'b1;
      end
      S_RUN: begin
        if (accept_halt) begin
          state_d = S_HALT;
          valid_d = 1'b0;
        end else if (accept_br) begin
          // The word fetched for the old stream arrives next cycle and is squashed.
          addr_d  = target;
          valid_d = 1'b0;
        end else if (!stall) begin
          pc_d    = addr_q;
          addr_d  = addr_q + PC_W'(1);
          valid_d = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      pc_q    <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      pc_q    <= pc_d;
      valid_q <= valid_d;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed self-checking bench for fetch_unit

module tb_fetch_unit;

  logic       clk;
  logic       reset;
  logic       start;
  logic       stall;
  logic       br_taken;
  logic [3:0] br_imm;
  logic [9:0] imem_addr;
  logic [8:0] imem_data;
  logic [8:0] instr;
  logic       instr_valid;
  logic [9:0] pc_out;
  logic       done;
  logic       lut_we;
  logic [3:0] lut_idx;
  logic [9:0] lut_data;

  logic       reset4;
  logic       start4;
  logic [3:0] imem_addr4;
  logic [8:0] imem_data4;
  logic [8:0] instr4;
  logic       instr_valid4;
  logic [3:0] pc_out4;
  logic       done4;
  logic       zero1;
  logic [3:0] zero4;

  logic [8:0] rom [0:1023];

  int n_tests;
  int n_fail;

  fetch_unit #(.PC_W(10)) dut (
    .clk(clk), .reset(reset), .start(start), .stall(stall),
    .br_taken(br_taken), .br_imm(br_imm), .imem_addr(imem_addr),
    .imem_data(imem_data), .instr(instr), .instr_valid(instr_valid),
    .pc_out(pc_out), .done(done)
`ifdef FETCH_BRANCH_LUT_EN
    , .lut_we(lut_we), .lut_idx(lut_idx), .lut_data(lut_data)
`endif
  );

  fetch_unit #(.PC_W(4)) dut4 (
    .clk(clk), .reset(reset4), .start(start4), .stall(zero1),
    .br_taken(zero1), .br_imm(zero4), .imem_addr(imem_addr4),
    .imem_data(imem_data4), .instr(instr4), .instr_valid(instr_valid4),
    .pc_out(pc_out4), .done(done4)
`ifdef FETCH_BRANCH_LUT_EN
    , .lut_we(zero1), .lut_idx(zero4), .lut_data(zero4)
`endif
  );

  always #5 clk = ~clk;

  // Synchronous ROM whose read port is held while the fetch stage stalls.
  always @(posedge clk) begin
    if (!stall) imem_data <= rom[imem_addr];
  end

  assign imem_data4 = 9'h000;
  assign zero1      = 1'b0;
  assign zero4      = 4'h0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic restart_main;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
  endtask

  initial begin
    n_tests  = 0;
    n_fail   = 0;
    clk      = 1'b0;
    reset    = 1'b1;
    start    = 1'b0;
    stall    = 1'b0;
    br_taken = 1'b0;
    br_imm   = 4'h0;
    lut_we   = 1'b0;
    lut_idx  = 4'h0;
    lut_data = 10'h000;
    reset4   = 1'b1;
    start4   = 1'b0;
    for (int i = 0; i < 1024; i++) rom[i] = 9'(i);
    rom[5] = 9'h1FF;

    // Reset values and idle hold
    tick();
    tick();
    check_eq("rst_addr",  32'(imem_addr),   32'h0);
    check_eq("rst_pc",    32'(pc_out),      32'h0);
    check_eq("rst_valid", 32'(instr_valid), 32'h0);
    check_eq("rst_done",  32'(done),        32'h0);
    reset = 1'b0;
    tick();
    tick();
    check_eq("idle_valid", 32'(instr_valid), 32'h0);
    check_eq("idle_addr",  32'(imem_addr),   32'h0);

    // Start, sequential fetch, halt at address 5
    start = 1'b1;
    tick();
    start = 1'b0;
    check_eq("prime_valid", 32'(instr_valid), 32'h0);
    check_eq("prime_addr",  32'(imem_addr),   32'h0);
    tick();
    check_eq("first_valid", 32'(instr_valid), 32'h1);
    check_eq("first_pc",    32'(pc_out),      32'h0);
    check_eq("first_instr", 32'(instr),       32'h0);
    for (int p = 1; p <= 5; p++) begin
      tick();
      check_eq("seq_pc",    32'(pc_out),      32'(p));
      check_eq("seq_valid", 32'(instr_valid), 32'h1);
    end
    check_eq("halt_instr", 32'(instr), 32'h1FF);
    tick();
    check_eq("halt_done",  32'(done),        32'h1);
    check_eq("halt_valid", 32'(instr_valid), 32'h0);
    check_eq("halt_addr",  32'(imem_addr),   32'h6);
    tick();
    check_eq("halt_done2", 32'(done),      32'h1);
    check_eq("halt_addr2", 32'(imem_addr), 32'h6);

    // Stall for three cycles at pc 2; br_taken during stall is ignored
    rom[5] = 9'h005;
    restart_main();
`ifdef FETCH_BRANCH_LUT_EN
    lut_we   = 1'b1;
    lut_idx  = 4'h3;
    lut_data = 10'h120;
    tick();
    lut_we   = 1'b0;
`endif
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    tick();
    check_eq("pre_stall_pc", 32'(pc_out), 32'h2);
    stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      if (k == 2) begin
        br_taken = 1'b1;
        br_imm   = 4'h3;
      end
      tick();
      check_eq("stall_pc",    32'(pc_out),      32'h2);
      check_eq("stall_instr", 32'(instr),       32'h2);
      check_eq("stall_valid", 32'(instr_valid), 32'h1);
    end
    stall    = 1'b0;
    br_taken = 1'b0;
    tick();
    check_eq("release_pc",    32'(pc_out), 32'h3);
    check_eq("release_instr", 32'(instr),  32'h3);

`ifdef FETCH_BRANCH_LUT_EN
    // Table redirect at pc 4 with a same-cycle overwrite of the entry
    tick();
    check_eq("lut_pre_pc", 32'(pc_out), 32'h4);
    br_taken = 1'b1;
    br_imm   = 4'h3;
    lut_we   = 1'b1;
    lut_idx  = 4'h3;
    lut_data = 10'h055;
    tick();
    br_taken = 1'b0;
    lut_we   = 1'b0;
    check_eq("lut_bubble", 32'(instr_valid), 32'h0);
    check_eq("lut_addr",   32'(imem_addr),   32'h120);
    tick();
    check_eq("lut_tgt_pc",    32'(pc_out),      32'h120);
    check_eq("lut_tgt_valid", 32'(instr_valid), 32'h1);
    check_eq("lut_tgt_instr", 32'(instr),       32'h120);
    br_taken = 1'b1;
    tick();
    br_taken = 1'b0;
    tick();
    check_eq("lut_new_pc", 32'(pc_out), 32'h055);
`else
    // Relative redirect: pc 8 with br_imm = -2
    for (int k = 0; k < 5; k++) tick();
    check_eq("br_pre_pc", 32'(pc_out), 32'h8);
    br_taken = 1'b1;
    br_imm   = 4'hE;
    tick();
    br_taken = 1'b0;
    check_eq("br_bubble", 32'(instr_valid), 32'h0);
    check_eq("br_addr",   32'(imem_addr),   32'h6);
    tick();
    check_eq("br_tgt_pc",    32'(pc_out),      32'h6);
    check_eq("br_tgt_valid", 32'(instr_valid), 32'h1);
    check_eq("br_tgt_instr", 32'(instr),       32'h6);
`endif

    // Halt and redirect on the same instruction: halt wins; restart later
    rom[3] = 9'h1FF;
    restart_main();
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    tick();
    tick();
    check_eq("hb_pc",    32'(pc_out), 32'h3);
    check_eq("hb_instr", 32'(instr),  32'h1FF);
    br_taken = 1'b1;
    br_imm   = 4'h1;
    tick();
    br_taken = 1'b0;
    check_eq("hb_done",  32'(done),        32'h1);
    check_eq("hb_valid", 32'(instr_valid), 32'h0);
    check_eq("hb_addr",  32'(imem_addr),   32'h4);
    tick();
    check_eq("hb_addr_frozen", 32'(imem_addr), 32'h4);
    start = 1'b1;
    tick();
    start = 1'b0;
    check_eq("restart_done", 32'(done),      32'h0);
    check_eq("restart_addr", 32'(imem_addr), 32'h0);
    tick();
    check_eq("restart_pc",    32'(pc_out),      32'h0);
    check_eq("restart_valid", 32'(instr_valid), 32'h1);
    rom[3] = 9'h003;
    reset = 1'b1;

    // PC_W = 4 wrap, then asynchronous reset mid-run
    reset4 = 1'b0;
    tick();
    start4 = 1'b1;
    tick();
    start4 = 1'b0;
    for (int p = 0; p < 16; p++) begin
      tick();
      check_eq("w4_pc", 32'(pc_out4), 32'(p));
    end
    tick();
    check_eq("w4_wrap_pc",    32'(pc_out4),      32'h0);
    check_eq("w4_wrap_valid", 32'(instr_valid4), 32'h1);
    tick();
    reset4 = 1'b1;
    #1;
    check_eq("arst_addr",  32'(imem_addr4),   32'h0);
    check_eq("arst_pc",    32'(pc_out4),      32'h0);
    check_eq("arst_valid", 32'(instr_valid4), 32'h0);
    check_eq("arst_done",  32'(done4),        32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
